// File: rtl/vtiming_gen_if.sv
// vtiming_gen_if: raster timing bundle between the pixel-enable source,
// the timing generator and the pixel fetch / colour output stages.
//   PixelEn      - pixel-clock enable into the generator
//   PixelCounter - horizontal position (XBITS wide)
//   LineCounter  - vertical position (YBITS wide)
//   HSync/VSync  - polarity-configured sync levels
//   Active       - both axes inside their visible region
//   LineStart    - one-cycle strobe on entry to pixel 0 of a line
//   FrameStart   - one-cycle strobe on entry to (0,0)
// The master modport belongs to the timing generator; the slave modport
// belongs to the stage that supplies PixelEn and consumes the timing.
interface vtiming_gen_if #(
    parameter int XBITS = 10,
    parameter int YBITS = 10
);
    logic             PixelEn;
    logic [XBITS-1:0] PixelCounter;
    logic [YBITS-1:0] LineCounter;
    logic             HSync;
    logic             VSync;
    logic             Active;
    logic             LineStart;
    logic             FrameStart;

    modport master (
        input  PixelEn,
        output PixelCounter, LineCounter, HSync, VSync, Active,
               LineStart, FrameStart
    );

    modport slave (
        output PixelEn,
        input  PixelCounter, LineCounter, HSync, VSync, Active,
               LineStart, FrameStart
    );
endinterface

// File: rtl/vtiming_gen.sv
// vtiming_gen: parametrised raster timing generator.
// Horizontal/vertical counters advance on PixelEn; per-axis phase FSMs
// (ACTIVE -> FRONT -> SYNC -> BACK) drive sync, active-video and the
// line/frame start strobes. Every output is registered on the same edge
// as the counters, so flags always describe the current position.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - synchronous, active-high; has priority over PixelEn
//   vt    - vtiming_gen_if.master (PixelEn in, timing outputs out)
module vtiming_gen #(
    parameter int          XBITS     = 10,
    parameter int          YBITS     = 10,
    parameter int unsigned HACTIVE   = 640,
    parameter int unsigned HFP       = 16,
    parameter int unsigned HSYNC     = 96,
    parameter int unsigned HBP       = 48,
    parameter int unsigned VACTIVE   = 480,
    parameter int unsigned VFP       = 10,
    parameter int unsigned VSYNC     = 2,
    parameter int unsigned VBP       = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic          Clk,
    input  logic          Reset,
    vtiming_gen_if.master vt
);

    localparam int unsigned H_TOTAL     = HACTIVE + HFP + HSYNC + HBP;
    localparam int unsigned V_TOTAL     = VACTIVE + VFP + VSYNC + VBP;

    // Last position of each phase; a transition fires on the enabled edge
    // that leaves this position.
    localparam int unsigned H_ACT_LAST  = HACTIVE - 1;
    localparam int unsigned H_FP_LAST   = HACTIVE + HFP - 1;
    localparam int unsigned H_SYNC_LAST = HACTIVE + HFP + HSYNC - 1;
    localparam int unsigned H_LAST      = H_TOTAL - 1;
    localparam int unsigned V_ACT_LAST  = VACTIVE - 1;
    localparam int unsigned V_FP_LAST   = VACTIVE + VFP - 1;
    localparam int unsigned V_SYNC_LAST = VACTIVE + VFP + VSYNC - 1;
    localparam int unsigned V_LAST      = V_TOTAL - 1;

    if (longint'(H_LAST) >= (longint'(1) << XBITS)) begin : g_xbits_check
        $error("vtiming_gen: XBITS=%0d cannot hold H_TOTAL-1=%0d", XBITS, H_LAST);
    end
    if (longint'(V_LAST) >= (longint'(1) << YBITS)) begin : g_ybits_check
        $error("vtiming_gen: YBITS=%0d cannot hold V_TOTAL-1=%0d", YBITS, V_LAST);
    end

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // One phase step for either axis. A zero-length porch is skipped by
    // jumping straight to the following phase on the same edge.
    function automatic phase_t step_phase(
        input phase_t      cur,
        input int unsigned pos,
        input int unsigned act_last,
        input int unsigned fp_last,
        input int unsigned sync_last,
        input int unsigned tot_last,
        input logic        has_fp,
        input logic        has_bp
    );
        phase_t nxt;
        nxt = cur;
        case (cur)
            PH_ACTIVE: if (pos == act_last)  nxt = has_fp ? PH_FRONT : PH_SYNC;
            PH_FRONT:  if (pos == fp_last)   nxt = PH_SYNC;
            PH_SYNC:   if (pos == sync_last) nxt = has_bp ? PH_BACK : PH_ACTIVE;
            PH_BACK:   if (pos == tot_last)  nxt = PH_ACTIVE;
            default:                         nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

    logic [XBITS-1:0] pix_q;
    logic [YBITS-1:0] line_q;
    phase_t           h_state;
    phase_t           v_state;
    logic             hsync_q;
    logic             vsync_q;
    logic             active_q;
    logic             line_start_q;
    logic             frame_start_q;

    logic             h_wrap;
    logic             v_wrap;
    logic [XBITS-1:0] pix_nxt;
    logic [YBITS-1:0] line_nxt;
    phase_t           h_nxt;
    phase_t           v_nxt;

    always_comb begin
        h_wrap   = (pix_q == XBITS'(H_LAST));
        v_wrap   = (line_q == YBITS'(V_LAST));
        pix_nxt  = h_wrap ? '0 : pix_q + XBITS'(1);
        line_nxt = line_q;
        v_nxt    = v_state;
        h_nxt    = step_phase(h_state, 32'(pix_q), H_ACT_LAST, H_FP_LAST,
                              H_SYNC_LAST, H_LAST, HFP != 0, HBP != 0);
        // The vertical axis only moves on a line wrap, which keeps VSync
        // aligned with PixelCounter returning to 0.
        if (h_wrap) begin
            line_nxt = v_wrap ? '0 : line_q + YBITS'(1);
            v_nxt    = step_phase(v_state, 32'(line_q), V_ACT_LAST, V_FP_LAST,
                                  V_SYNC_LAST, V_LAST, VFP != 0, VBP != 0);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_q         <= '0;
            line_q        <= '0;
            h_state       <= PH_ACTIVE;
            v_state       <= PH_ACTIVE;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (vt.PixelEn) begin
                pix_q         <= pix_nxt;
                line_q        <= line_nxt;
                h_state       <= h_nxt;
                v_state       <= v_nxt;
                // Flags are computed from the next phase so they line up
                // with the counter value loaded on this same edge.
                hsync_q       <= (h_nxt == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
                vsync_q       <= (v_nxt == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
                active_q      <= (h_nxt == PH_ACTIVE) && (v_nxt == PH_ACTIVE);
                line_start_q  <= h_wrap;
                frame_start_q <= h_wrap && v_wrap;
            end
        end
    end

    assign vt.PixelCounter = pix_q;
    assign vt.LineCounter  = line_q;
    assign vt.HSync        = hsync_q;
    assign vt.VSync        = vsync_q;
    assign vt.Active       = active_q;
    assign vt.LineStart    = line_start_q;
    assign vt.FrameStart   = frame_start_q;

endmodule
